// File: rtl/pid_pkg.sv
// Shared types and helpers for the fixed-point PID controller.
// Holds the sequencing states, default widths and the saturating helper.
package pid_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ERR   = 3'd1,
    TERMS = 3'd2,
    SUM   = 3'd3,
    OUT   = 3'd4
  } state_e;

  localparam int PID_DW   = 8;
  localparam int PID_GW   = 8;
  localparam int PID_FRAC = 4;
  localparam int PID_IW   = 24;
  // Headroom of the final sum over the integrator width.
  localparam int SUM_XTRA = 2;
  // Wide scratch width for integrator arithmetic before clamping.
  localparam int ACC_W    = 64;

  // Symmetric clamp to +/-(2^(width-1)-1).
  function automatic logic signed [ACC_W-1:0] sat_signed(
    input logic signed [ACC_W-1:0] value,
    input int                      width
  );
    logic signed [ACC_W-1:0] lim;
    lim = (64'sd1 <<< (width - 1)) - 64'sd1;
    if (value > lim) return lim;
    if (value < -lim) return -lim;
    return value;
  endfunction

endpackage

// File: rtl/pid_controller_q_clamp.sv
// Output limiter: folds the shifted PID sum into the unsigned actuator range.
// Reports which rail (if any) was hit.
module pid_clamp #(
  parameter int DW = 8,
  parameter int RW = 26
) (
  input  logic signed [RW-1:0] r,
  output logic [DW-1:0]        control_out,
  output logic                 sat_hi,
  output logic                 sat_lo
);

  localparam logic signed [RW-1:0] MAXV = RW'((64'd1 << DW) - 64'd1);

  // Rail detection and selection of the clamped value.
  always_comb begin
    sat_hi      = (r > MAXV);
    sat_lo      = r[RW-1];
    control_out = r[DW-1:0];
    if (sat_hi) control_out = '1;
    else if (sat_lo) control_out = '0;
  end

endmodule

// File: rtl/pid_controller_q.sv
// Multi-cycle PID with runtime gains, saturating integrator and anti-windup.
// One sample in flight: ERR, TERMS, SUM, OUT, then ready again.
module pid_controller_q
  import pid_pkg::*;
#(
  parameter int DW   = PID_DW,
  parameter int GW   = PID_GW,
  parameter int FRAC = PID_FRAC,
  parameter int IW   = PID_IW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_valid,
  output logic          sample_ready,
  input  logic [DW-1:0] setpoint,
  input  logic [DW-1:0] feedback,
  input  logic [GW-1:0] kp,
  input  logic [GW-1:0] ki,
  input  logic [GW-1:0] kd,
  input  logic          clear_int,
  output logic          out_valid,
  output logic [DW-1:0] control_out,
  output logic          sat_hi,
  output logic          sat_lo
);

  localparam int EW  = DW + 1;
  localparam int DEW = DW + 2;
  localparam int SW  = IW + SUM_XTRA;

  state_e state_q, state_d;
  logic [DW-1:0] sp_q, sp_d, fb_q, fb_d;
  logic [GW-1:0] kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic clr_q, clr_d;
  logic signed [EW-1:0] e_q, e_d, prev_q, prev_d;
  logic signed [SW-1:0] p_q, p_d, d_q, d_d, r_q, r_d;
  logic signed [IW-1:0] integ_q, integ_d;
  logic [DW-1:0] out_q, out_d;
  logic hi_q, hi_d, lo_q, lo_d, ov_q, ov_d;

  logic [DW-1:0] c_out;
  logic c_hi, c_lo;

  logic signed [EW-1:0] prev_eff;
  logic signed [DEW-1:0] de;
  logic signed [GW:0] kp_s, ki_s, kd_s;
  logic signed [ACC_W-1:0] base, inc;
  logic signed [SW-1:0] s;
  logic hold;

  assign sample_ready = (state_q == IDLE) & ~rst;
  assign out_valid    = ov_q;
  assign control_out  = out_q;
  assign sat_hi       = hi_q;
  assign sat_lo       = lo_q;

  pid_clamp #(.DW(DW), .RW(SW)) u_clamp (
    .r           (r_q),
    .control_out (c_out),
    .sat_hi      (c_hi),
    .sat_lo      (c_lo)
  );

  // Sequencing and datapath next-state for one sample per pass.
  always_comb begin
    state_d  = state_q;
    sp_d     = sp_q;
    fb_d     = fb_q;
    kp_d     = kp_q;
    ki_d     = ki_q;
    kd_d     = kd_q;
    clr_d    = clr_q;
    e_d      = e_q;
    prev_d   = prev_q;
    p_d      = p_q;
    d_d      = d_q;
    r_d      = r_q;
    integ_d  = integ_q;
    out_d    = out_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    ov_d     = 1'b0;
    kp_s     = $signed({1'b0, kp_q});
    ki_s     = $signed({1'b0, ki_q});
    kd_s     = $signed({1'b0, kd_q});
    prev_eff = clr_q ? '0 : prev_q;
    de       = DEW'(e_q) - DEW'(prev_eff);
    base     = clr_q ? '0 : ACC_W'(integ_q);
    inc      = ACC_W'(ki_s) * ACC_W'(e_q);
    hold     = (hi_q & ~e_q[EW-1] & (|e_q)) | (lo_q & e_q[EW-1]);
    s        = SW'(p_q) + SW'(integ_q) + d_q;
    unique case (state_q)
      IDLE: begin
        if (sample_valid & sample_ready) begin
          sp_d    = setpoint;
          fb_d    = feedback;
          kp_d    = kp;
          ki_d    = ki;
          kd_d    = kd;
          clr_d   = clear_int;
          state_d = ERR;
        end
      end
      ERR: begin
        e_d     = $signed({1'b0, sp_q}) - $signed({1'b0, fb_q});
        state_d = TERMS;
      end
      TERMS: begin
        p_d = SW'(kp_s) * SW'(e_q);
        d_d = SW'(kd_s) * SW'(de);
        if (hold) integ_d = IW'(base);
        else integ_d = IW'(sat_signed(base + inc, IW));
        state_d = SUM;
      end
      SUM: begin
        r_d     = s >>> FRAC;
        state_d = OUT;
      end
      OUT: begin
        out_d   = c_out;
        hi_d    = c_hi;
        lo_d    = c_lo;
        prev_d  = e_q;
        ov_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sp_q    <= '0;
      fb_q    <= '0;
      kp_q    <= '0;
      ki_q    <= '0;
      kd_q    <= '0;
      clr_q   <= 1'b0;
      e_q     <= '0;
      prev_q  <= '0;
      p_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      integ_q <= '0;
      out_q   <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      fb_q    <= fb_d;
      kp_q    <= kp_d;
      ki_q    <= ki_d;
      kd_q    <= kd_d;
      clr_q   <= clr_d;
      e_q     <= e_d;
      prev_q  <= prev_d;
      p_q     <= p_d;
      d_q     <= d_d;
      r_q     <= r_d;
      integ_q <= integ_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ov_q    <= ov_d;
    end
  end

endmodule

// File: tb/tb_pid_controller_q.sv
// Randomised and directed bench for pid_controller_q.
// Expected results come from an arithmetic PID model.
module tb_pid_controller_q;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic [7:0] setpoint = '0, feedback = '0;
  logic [7:0] kp = '0, ki = '0, kd = '0;
  logic       clear_int = 1'b0;
  logic       out_valid;
  logic [7:0] control_out;
  logic       sat_hi, sat_lo;

  int n_tests = 0;
  int n_fail  = 0;

  longint m_integ = 0, m_prev = 0;
  bit     m_hi = 0, m_lo = 0;
  longint m_out = 0;

  localparam longint IMAX = (64'sd1 <<< 23) - 1;

  pid_controller_q #(.DW(8), .GW(8), .FRAC(4), .IW(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .setpoint     (setpoint),
    .feedback     (feedback),
    .kp           (kp),
    .ki           (ki),
    .kd           (kd),
    .clear_int    (clear_int),
    .out_valid    (out_valid),
    .control_out  (control_out),
    .sat_hi       (sat_hi),
    .sat_lo       (sat_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_integ = 0;
    m_prev  = 0;
    m_hi    = 0;
    m_lo    = 0;
  endtask

  // Reference PID: integer arithmetic, floor division by 2^FRAC.
  task automatic model_step(input int sp, input int fb, input int gp,
                            input int gi, input int gd, input bit clr);
    longint e, p, d, s, r;
    e = sp - fb;
    if (clr) begin
      m_integ = 0;
      m_prev  = 0;
    end
    p = gp * e;
    d = gd * (e - m_prev);
    if (!((m_hi && e > 0) || (m_lo && e < 0))) begin
      m_integ = m_integ + gi * e;
      if (m_integ > IMAX) m_integ = IMAX;
      if (m_integ < -IMAX) m_integ = -IMAX;
    end
    s = p + m_integ + d;
    r = s >>> 4;
    m_hi   = (r > 255);
    m_lo   = (r < 0);
    m_out  = m_hi ? 255 : (m_lo ? 0 : r);
    m_prev = e;
  endtask

  task automatic run_sample(input int sp, input int fb, input int gp,
                            input int gi, input int gd, input bit clr,
                            input int exp_out);
    int  n;
    bit  seen;
    n = 0;
    while (!sample_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    setpoint     = 8'(sp);
    feedback     = 8'(fb);
    kp           = 8'(gp);
    ki           = 8'(gi);
    kd           = 8'(gd);
    clear_int    = clr;
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    seen = 0;
    for (n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    model_step(sp, fb, gp, gi, gd, clr);
    check("latency", seen ? n : 0, 5);
    check("control_out", control_out, m_out);
    check("sat_hi", sat_hi, m_hi);
    check("sat_lo", sat_lo, m_lo);
    if (exp_out >= 0) check("directed_out", control_out, exp_out);
    @(negedge clk);
    check("strobe_width", out_valid, 0);
    check("ready_after", sample_ready, 1);
  endtask

  initial begin
    int last, strobes, cyc;

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_control", control_out, 0);
    check("rst_sat_hi", sat_hi, 0);
    check("rst_sat_lo", sat_lo, 0);
    check("rst_ready", sample_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1 check("ready_release", sample_ready, 1);
    @(negedge clk);

    // P only, then both rails
    run_sample(100, 60, 8'h20, 0, 0, 1, 80);
    run_sample(255, 0, 8'h20, 0, 0, 0, 255);
    check("clamp_hi_flag", sat_hi, 1);
    run_sample(0, 50, 8'h20, 0, 0, 0, 0);
    check("clamp_lo_flag", sat_lo, 1);

    // I only with clear
    run_sample(20, 10, 0, 8'h10, 0, 1, 10);
    run_sample(20, 10, 0, 8'h10, 0, 0, 20);
    run_sample(20, 10, 0, 8'h10, 0, 0, 30);
    run_sample(20, 10, 0, 8'h10, 0, 1, 10);

    // anti-windup
    run_sample(200, 0, 0, 8'h10, 0, 1, 200);
    run_sample(200, 0, 0, 8'h10, 0, 0, 255);
    run_sample(200, 0, 0, 8'h10, 0, 0, 255);
    check("windup_integ", m_integ, 6400);
    check("windup_dut_integ", dut.integ_q, 6400);
    run_sample(0, 10, 0, 8'h10, 0, 0, 255);
    check("unwind_dut_integ", dut.integ_q, 6240);

    // D only with derivative kick
    run_sample(50, 50, 0, 0, 8'h10, 1, 0);
    run_sample(70, 50, 0, 0, 8'h10, 0, 20);
    run_sample(70, 50, 0, 0, 8'h10, 0, 0);

    // randomised samples
    for (int i = 0; i < 40; i++) begin
      run_sample($urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), ($urandom_range(0, 7) == 0), -1);
    end

    // valid held high: one accept every 5 cycles
    setpoint     = 8'd120;
    feedback     = 8'd20;
    kp           = 8'h10;
    ki           = 8'h00;
    kd           = 8'h08;
    clear_int    = 1'b0;
    sample_valid = 1'b1;
    last    = -1;
    strobes = 0;
    for (cyc = 0; cyc < 60 && strobes < 5; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        model_step(120, 20, 8'h10, 0, 8'h08, 0);
        check("hold_out", control_out, m_out);
        if (last >= 0) check("hold_spacing", cyc - last, 5);
        last = cyc;
        strobes++;
        if (strobes == 5) sample_valid = 1'b0;
      end
    end
    check("hold_strobes", strobes, 5);
    @(negedge clk);

    // reset during SUM
    setpoint     = 8'd90;
    feedback     = 8'd10;
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_state", dut.state_q, 3);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_strobe", out_valid, 0);
    end
    check("rst_mid_control", control_out, 0);
    check("rst_mid_ready", sample_ready, 0);
    rst = 1'b0;
    #1 check("rst_mid_ready_rel", sample_ready, 1);
    check("rst_mid_integ", dut.integ_q, 0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_mid_quiet", out_valid, 0);
    end
    run_sample(10, 0, 0, 8'h10, 0, 0, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
